// File: rtl/counter_display_pkg.sv
// Shared definitions for the counter display stage: converter states,
// seven-segment codes and digit count.
package counter_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 3;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/counter_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits,
// one conversion every 10 cycles, free-running.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        valid
);
  import counter_display_pkg::*;

  conv_state_t state_reg;
  logic [7:0]  shift_reg;
  logic [11:0] scratch_reg;
  logic [2:0]  iter_reg;
  logic [11:0] adjusted;

  // Add-3 correction on each nibble before it is doubled by the shift
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
      assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                   scratch_reg[gi*4 +: 4] + 4'd3 :
                                   scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= 8'd0;
      scratch_reg <= 12'd0;
      iter_reg    <= 3'd0;
      bcd         <= 12'd0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          shift_reg   <= bin;
          scratch_reg <= 12'd0;
          iter_reg    <= 3'd0;
          state_reg   <= SHIFT;
        end
        SHIFT: begin
          {scratch_reg, shift_reg} <= {adjusted, shift_reg} << 1;
          iter_reg <= iter_reg + 3'd1;
          if (iter_reg == 3'd7) state_reg <= LATCH;
        end
        LATCH: begin
          bcd       <= scratch_reg;
          valid     <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/counter_display_driver.sv
// Display stage for the 8-bit counter: BCD conversion plus a 3-digit
// multiplexed common-anode seven-segment scan with leading-zero blanking.
module counter_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [11:0] bcd,
  output logic        bcd_valid
);
  import counter_display_pkg::*;

  localparam int TICK_W = $clog2(REFRESH_DIV);

  logic [TICK_W-1:0]     tick_reg;
  logic [1:0]            digit_idx_reg;
  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]            digit_seg [NUM_DIGITS];
  logic [6:0]            seg_next;
  logic [3:0]            an_next;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .bin   (value),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  // A digit is blank when it and every more significant digit are zero
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_ones
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (bcd[4*NUM_DIGITS-1 : 4*gi] == '0);
      end
      assign digit_seg[gi] = blank[gi] ? SEG_BLANK : seg_decode(bcd[gi*4 +: 4]);
    end
  endgenerate

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'b1111;
    case (digit_idx_reg)
      2'd0: begin seg_next = digit_seg[0]; an_next = 4'b1110; end
      2'd1: begin seg_next = digit_seg[1]; an_next = 4'b1101; end
      2'd2: begin seg_next = digit_seg[2]; an_next = 4'b1011; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg      <= '0;
      digit_idx_reg <= 2'd0;
      seg           <= SEG_BLANK;
      an            <= 4'b1111;
      dp            <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= 1'b1;
      if (tick_reg == TICK_W'(REFRESH_DIV - 1)) begin
        tick_reg      <= '0;
        digit_idx_reg <= (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
      end else begin
        tick_reg <= tick_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_display_driver.sv
// Bench for counter_display_driver: directed and random values checked
// cycle by cycle against a decimal-arithmetic reference model.
module tb_counter_display_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  value = 8'd0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [11:0] bcd;
  logic        bcd_valid;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int          n = 0;
  logic [7:0]  cap_val = 8'd0;
  logic [11:0] exp_bcd = 12'h000;
  logic        exp_valid = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'b1111;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  counter_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] disp(input int idx, input logic [11:0] b);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (idx == 0) disp = seg_tab[o];
    else if (idx == 1) disp = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    else disp = (h == 0) ? 7'h7F : seg_tab[h];
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0]  v;
    logic        r;
    logic [11:0] prev_bcd;
    int          idx;
    v = value;
    r = reset;
    @(posedge clk);
    #1;
    if (r) begin
      n = 0;
      exp_bcd = 12'h000;
      exp_valid = 1'b0;
      exp_seg = 7'h7F;
      exp_an = 4'b1111;
    end else begin
      prev_bcd = exp_bcd;
      idx = (n / DIV) % 3;
      exp_an = 4'b1111 & ~(4'b0001 << idx);
      exp_seg = disp(idx, prev_bcd);
      if (n % 10 == 0) cap_val = v;
      exp_valid = (n % 10 == 9);
      if (exp_valid) exp_bcd = to_bcd(int'(cap_val));
      n++;
    end
    chk("bcd", bcd, exp_bcd);
    chk("bcd_valid", 12'(bcd_valid), 12'(exp_valid));
    chk("seg", 12'(seg), 12'(exp_seg));
    chk("an", 12'(an), 12'(exp_an));
    chk("dp", 12'(dp), 12'h001);
    if (bcd_valid)
      $display("conv: n=%0d bcd=%h", n, bcd);
  endtask

  initial begin
    // Reset with value 0, then run several conversions and frames
    reset = 1'b1;
    value = 8'd0;
    repeat (3) step();
    reset = 1'b0;
    repeat (40) step();

    value = 8'd255;
    repeat (36) step();

    value = 8'd7;
    repeat (24) step();
    value = 8'd105;
    repeat (24) step();

    // Value changes two cycles after a capture must not affect that conversion
    value = 8'd100;
    for (int i = 0; i < 12 && (n % 10) != 1; i++) step();
    step();
    step();
    value = 8'd200;
    repeat (25) step();

    // Counter-style ramp across the 255 -> 0 wrap
    value = 8'd250;
    for (int i = 0; i < 40; i++) begin
      step();
      value = value + 8'd1;
    end
    value = 8'd5;
    for (int i = 0; i < 40; i++) begin
      step();
      value = value - 8'd1;
    end

    // Reset in the middle of SHIFT
    value = 8'd255;
    for (int i = 0; i < 12 && (n % 10) != 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    value = 8'd0;
    repeat (24) step();

    // Reset while the hundreds digit is being scanned
    value = 8'd255;
    repeat (20) step();
    for (int i = 0; i < 20 && !(((n / DIV) % 3) == 2 && (n % DIV) == 2); i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    value = 8'd0;
    repeat (24) step();

    // Random values, occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) value = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_display_driver.md
# counter_display_driver

Downstream display stage for the 8-bit up/down counter. It continuously samples the counter's unsigned `Q` value and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter. It time-multiplexes those digits onto a common-anode 4-digit seven-segment display with leading-zero blanking. All outputs are registered; one clock domain.

## Interface
- `REFRESH_DIV`, 50000: clk cycles each digit stays enabled; legal range 2..2^20.
- `clk` input 1: rising-edge clock, same domain as the counter.
- `reset` input 1: synchronous, active-high; clock `clk`.
- `value` input 8: unsigned counter value, wired to counter `Q`.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` output 4: digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3] always 1.
- `dp` output 1: decimal point, active-low, constant 1.
- `bcd` output 12: last completed conversion {hundreds,tens,ones}.
- `bcd_valid` output 1: one-cycle pulse when `bcd` updates.

## Operation
- Reset values: `seg`=7'h7F, `an`=4'b1111, `dp`=1, `bcd`=12'h000, `bcd_valid`=0, converter state IDLE, digit index 0, tick counter 0.
- Converter FSM runs free-running and back-to-back:
  - IDLE: capture `value` into the shift register, clear the BCD scratch, go to SHIFT.
  - SHIFT: 8 iterations. On each iteration, first add 3 to any scratch nibble ≥5, then shift {scratch,shift} left 1. After the 8th iteration go to LATCH.
  - LATCH: copy scratch to `bcd`, pulse `bcd_valid`, go to IDLE.
- `value` changes during SHIFT/LATCH are ignored until the next IDLE capture; no partial results ever reach `bcd`.
- Scan: the tick counter counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→0. Index 3 is never used.
- `an` is one-hot-low for the current index: 1110, 1101, 1011.
- Blanking: hundreds is blank if its digit is 0. Tens is blank if both hundreds and tens are 0. Ones is never blank. A blank digit drives `seg`=7'h7F with its anode still enabled.
- Segment codes, 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Nibbles above 9 are impossible; they decode to 7F.
- Counter wrap 255→0 and 0→255 needs no special handling.

## Timing
- Conversion period is exactly 10 cycles: IDLE 1, SHIFT 8, LATCH 1.
- If `value` is captured at edge E0, `bcd` and `bcd_valid` update at E9 and the next capture occurs at E10.
- `seg`/`an` are registered from the current index and `bcd`. A new `bcd` appears on the enabled digit one cycle after `bcd_valid`.
- First edge after `reset` deasserts: `an`=1110, `seg`=7'h40 ("0").
- Each digit stays enabled for REFRESH_DIV cycles; a full frame is 3×REFRESH_DIV cycles.
- `reset` asserted mid-conversion or mid-scan returns everything to reset values on that edge. The in-flight conversion is discarded with no `bcd_valid` pulse.

## Structure
- Shared package `counter_display_pkg` holds:
  - converter state encodings IDLE/SHIFT/LATCH;
  - the segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - NUM_DIGITS=3.
- Sub-module `bin2bcd_seq` contains the converter FSM. Ports: clk, reset, bin[7:0], bcd[11:0], valid.
- The top level holds the tick counter, the digit index, blanking, and the segment decode.

## Test plan
- Reset release with `value`=0 and REFRESH_DIV=4 → first `bcd_valid` at the 10th edge with `bcd`=000. Display shows ones "0" (seg 40); tens and hundreds blank (7F).
- `value`=255 held → `bcd`=12'h255; scan shows an 1110/seg 12, 1101/12, 1011/24, each held 4 cycles, repeating.
- `value`=7 → `bcd`=007; tens and hundreds blank, ones seg 78. `value`=105 → `bcd`=105; tens displays "0" (seg 40), not blank.
- `value` changes 100→200 two cycles after capture → that conversion yields 100. The next conversion yields 200, with `bcd_valid` 10 cycles apart.
- Counter stimulus wraps 255→0 → `bcd` sequence 255, then 000, with no glitch values between `bcd_valid` pulses.
- `reset` pulsed during SHIFT and during hundreds scan → outputs at reset values that cycle, no `bcd_valid`. Restart matches the first scenario.
